// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: four-channel TDM receive demultiplexer.
// Serial bits are steered round-robin into four per-channel shift registers,
// aligned by SYNC. A complete frame set is presented on Y with a valid/ready
// handshake.
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds an even-parity bit per word).
module tdm_demux_4ch #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           EN,
  input  logic           D,
  input  logic           SYNC,
  input  logic           READY,
  output logic [4*W-1:0] Y,
  output logic           VALID,
  output logic           LOCK,
  output logic           SYNC_ERR,
  output logic           OVF,
  output logic           PERR
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned WL = W + 1;
`else
  localparam int unsigned WL = W;
`endif

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [1:0]      slot;
  logic [1:0]      eff_slot;
  logic [4:0]      bitcnt;
  logic [WL-1:0]   sr     [4];
  logic [WL-1:0]   sr_nxt [4];
  logic [4*W-1:0]  y_nxt;
  logic            start;
  logic            shift;
  logic            sync_err;
  logic            complete;
  logic            perr_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  // Next-state logic: the first SYNC sample acquires lock; lock is kept until reset
  always_comb begin
    state_nxt = state;
    if (state == HUNT && EN && SYNC) state_nxt = LOCKED;
  end

  // FSM outputs
  always_comb begin
    LOCK = (state == LOCKED);
  end

  // Sample classification and next shift-register contents.
  // A restart (acquire or resync) is treated as slot 0, bit 0; stale bits of the
  // other channels are shifted out before the next completion, so no clear is needed.
  always_comb begin
    start    = EN && SYNC && (state == HUNT || slot != 2'd0);
    sync_err = EN && SYNC && (state == LOCKED) && (slot != 2'd0);
    shift    = EN && (state == LOCKED || SYNC);
    eff_slot = start ? 2'd0 : slot;
    complete = EN && (state == LOCKED) && !start && (slot == 2'd3)
               && (bitcnt == 5'(WL - 1));
    y_nxt    = '0;
    perr_nxt = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      sr_nxt[i] = sr[i];
      if (shift && eff_slot == 2'(i)) sr_nxt[i] = {D, sr[i][WL-1:1]};
      y_nxt[i*W +: W] = sr_nxt[i][W-1:0];
`ifdef TDM_DEMUX_PARITY_EN
      if (^sr_nxt[i]) perr_nxt = 1'b1;
`endif
    end
  end

  // Slot/bit counters and channel shift registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot   <= '0;
      bitcnt <= '0;
      for (int unsigned i = 0; i < 4; i++) sr[i] <= '0;
    end else if (shift) begin
      for (int unsigned i = 0; i < 4; i++) sr[i] <= sr_nxt[i];
      slot <= eff_slot + 2'd1;
      if (start)                 bitcnt <= '0;
      else if (complete)         bitcnt <= '0;
      else if (slot == 2'd3)     bitcnt <= bitcnt + 5'd1;
    end
  end

  // Output word register, valid/ready handshake and error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y        <= '0;
      VALID    <= 1'b0;
      SYNC_ERR <= 1'b0;
      OVF      <= 1'b0;
    end else begin
      SYNC_ERR <= sync_err;
      OVF      <= 1'b0;
      if (complete && (!VALID || READY)) begin
        Y     <= y_nxt;
        VALID <= 1'b1;
      end else if (complete) begin
        OVF <= 1'b1;
      end else if (READY) begin
        VALID <= 1'b0;
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Parity error pulse accompanies delivery of a word with a bad channel
  always_ff @(posedge clk) begin
    if (!rst_n) PERR <= 1'b0;
    else        PERR <= complete && (!VALID || READY) && perr_nxt;
  end
`else
  assign PERR = 1'b0;
`endif

endmodule

// File: doc/tdm_demux_4ch.md
# tdm_demux_4ch

Four-channel time-division demultiplexer: the receive end of the 4:1 serial TDM link that the team's 4:1 multiplexer drives. It takes one serial bit per enabled cycle, tracks a rotating 2-bit slot counter aligned by a frame-sync pulse, and steers each bit into one of four per-channel shift registers. When every channel has collected a full W-bit word, it presents all four words in parallel on a valid/ready output port. It sits between the serial line sampler and the parallel datapath.

## Interface
- W, default 4: bits per channel word (2..16).
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- EN  input  1  sample qualifier; D and SYNC are ignored when EN=0.
- D  input  1  serial TDM data bit.
- SYNC  input  1  marks the current D as slot 0 of a frame.
- READY  input  1  downstream accepts Y this cycle.
- Y  output  4W  channel words; Y[W-1:0]=ch0 … Y[4W-1:3W]=ch3.
- VALID  output  1  Y holds an unaccepted word.
- LOCK  output  1  frame alignment acquired.
- SYNC_ERR  output  1  one-cycle pulse: SYNC arrived off-boundary.
- OVF  output  1  one-cycle pulse: completed word dropped.
- PERR  output  1  one-cycle pulse: parity error (see Configuration).

## Operation
- Reset (rst_n=0 at clk edge) sets: state HUNT, slot=0, bitcnt=0, shift registers=0, Y=0, VALID=0, LOCK=0, SYNC_ERR=0, OVF=0, PERR=0. Reset overrides every other input, including mid-word.
- A sample is a clk edge with EN=1.
- HUNT: samples without SYNC are discarded. A sample with SYNC=1 takes D as ch0 bit 0, sets slot=1, bitcnt=0, and moves to LOCK with LOCK=1.
- LOCK: each sample shifts D into channel[slot], LSB first (bit k of a word arrives in frame k), then slot increments mod 4.
- After the slot-3 sample, bitcnt increments. When bitcnt=W-1 at slot 3, the word is complete and all four registers transfer to Y.
- SYNC in LOCK with slot=0: this is the normal case and does nothing extra.
- SYNC in LOCK with slot≠0: SYNC_ERR pulses. The sample is treated as slot 0, bit 0 (resync). The partial word is discarded and bitcnt=0. LOCK stays 1.
- Handshake:
  - VALID rises when a word transfers.
  - VALID falls on an edge with READY=1, unless a new word completes on that same edge. In that case Y reloads and VALID stays 1, with no OVF.
  - Completion while VALID=1 and READY=0: the new word is dropped, Y is unchanged, and OVF pulses.
- Y is stable while VALID=1 and READY=0.

## Timing
- The final bit (ch3, bit W-1) is sampled at edge N; Y and VALID are visible after edge N, so latency is 1 cycle.
- A word completes at most every 4W samples.
- SYNC_ERR, OVF and PERR are registered pulses, high for exactly the cycle after the triggering edge.
- EN=0 cycles freeze slot, bitcnt and the shift registers. The handshake still operates.

## Configuration
- TDM_DEMUX_PARITY_EN defined:
  - Each channel word is W+1 bits long; the last bit is even parity over the W data bits.
  - Completion occurs when bitcnt=W at slot 3. The parity bits are not placed on Y.
  - If any channel fails parity, PERR pulses in the same cycle VALID rises, and the word is still delivered.
- TDM_DEMUX_PARITY_EN undefined: words are W bits and PERR is tied to 0.

## Test plan
- Lock and deliver (W=4, no parity): SYNC on the first sample, then send ch0..ch3 = 4'hA, 4'h5, 4'hF, 4'h3 over 16 samples → LOCK=1 after the first sample; Y=16'h3F5A with VALID=1 one cycle after the 16th sample.
- Backpressure: hold READY=0 and stream a second frame set → Y stays at the first word, OVF pulses once at the second completion, VALID stays 1; READY=1 then clears VALID.
- Back-to-back accept: READY=1 on the exact edge a new word completes → Y updates, VALID stays 1, OVF=0.
- Misaligned SYNC: SYNC at slot 2 during bit 1 → SYNC_ERR pulses; the next complete word reflects only bits sent from that sample onward.
- EN gaps and reset: random EN=0 cycles inserted → same Y as the gapless run; rst_n=0 mid-word → all outputs 0, LOCK=0, and the block waits for SYNC.
- Parity (with TDM_DEMUX_PARITY_EN): ch2 sends 4'h7 with parity bit 0 → PERR pulses alongside VALID and Y[11:8]=4'h7.
